// File: rtl/axis_frame_arb_pkg.sv
// axis_frame_arb_pkg: shared types and helpers for the frame round-robin arbiter
//   state_t       arbiter FSM states (IDLE, LOCKED)
//   DEF_CNT_WIDTH default width of the per-input frame counters
//   idx_w(n)      index width for n requesters, never below 1 bit
package axis_frame_arb_pkg;
   typedef enum logic {IDLE, LOCKED} state_t;
   localparam int DEF_CNT_WIDTH = 32;
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/rr_priority_sel.sv
// rr_priority_sel: combinational round-robin picker
//   req_i        request vector, one bit per requester
//   last_grant_i most recently served requester; the search starts just after it
//   grant_o      index of the first requester after last_grant_i (wrapping)
//   any_req_o    at least one request is present
module rr_priority_sel #(
   parameter int N  = 2,
   parameter int IW = 1
)(
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_grant_i,
   output logic [IW-1:0] grant_o,
   output logic          any_req_o
);
   int d, best;
   // distance d counts positions after last_grant_i; the nearest requester wins
   always_comb begin
      grant_o   = '0;
      any_req_o = |req_i;
      best      = N;
      d         = 0;
      for (int i = 0; i < N; i++) begin
         d = (i + N - 1 - int'(last_grant_i)) % N;
         if (req_i[i] && d < best) begin
            best    = d;
            grant_o = IW'(i);
         end
      end
   end
endmodule

// File: rtl/axis_frame_rr_arbiter.sv
// axis_frame_rr_arbiter: frame-granular round-robin merge of INPUTS AXI-Stream sources onto one sink
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   din_data/last/valid/ready per-input streams, input i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   dout_data/last/valid/ready merged stream, passed through combinationally while LOCKED
//   grant_idx                 current owner, meaningful while busy=1
//   busy                      arbiter is LOCKED onto an owner
//   stats_clear, stats_frames per-input accepted-frame counters, present with AXIS_FRAME_ARB_STATS_EN
module axis_frame_rr_arbiter
   import axis_frame_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int INPUTS     = 2,
   parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
   localparam int IW        = idx_w(INPUTS)
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [INPUTS*DATA_WIDTH-1:0] din_data,
   input  logic [INPUTS-1:0]            din_last,
   input  logic [INPUTS-1:0]            din_valid,
   output logic [INPUTS-1:0]            din_ready,
   output logic [DATA_WIDTH-1:0]        dout_data,
   output logic                         dout_last,
   output logic                         dout_valid,
   input  logic                         dout_ready,
   output logic [IW-1:0]                grant_idx,
   output logic                         busy
`ifdef AXIS_FRAME_ARB_STATS_EN
   ,
   input  logic                         stats_clear,
   output logic [INPUTS*CNT_WIDTH-1:0]  stats_frames
`endif
);
   state_t state_q, state_d;
   logic [IW-1:0] grant_q, grant_d, last_q, last_d, sel;
   logic any_req, done;
   logic [DATA_WIDTH-1:0] lane [INPUTS];

   for (genvar g = 0; g < INPUTS; g++) begin : g_lane
      assign lane[g] = din_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_priority_sel #(.N(INPUTS), .IW(IW)) u_sel (
      .req_i        (din_valid),
      .last_grant_i (last_q),
      .grant_o      (sel),
      .any_req_o    (any_req)
   );

   always_comb begin
      busy       = state_q == LOCKED;
      grant_idx  = grant_q;
      dout_valid = busy & din_valid[grant_q];
      dout_last  = busy & din_last[grant_q];
      dout_data  = busy ? lane[grant_q] : '0;
      din_ready  = '0;
      for (int i = 0; i < INPUTS; i++) din_ready[i] = busy && dout_ready && grant_q == IW'(i);
      // an accepted last beat ends ownership; IDLE always follows, so each frame costs one bubble
      done       = dout_valid & dout_ready & dout_last;
      state_d    = busy ? (done ? IDLE : LOCKED) : (any_req ? LOCKED : IDLE);
      grant_d    = (!busy && any_req) ? sel : grant_q;
      last_d     = done ? grant_q : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IW'(INPUTS-1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

`ifdef AXIS_FRAME_ARB_STATS_EN
   logic [CNT_WIDTH-1:0] cnt_q [INPUTS];
   for (genvar g = 0; g < INPUTS; g++) begin : g_stat
      // clear dominates a same-cycle increment
      always_ff @(posedge clk) begin
         if (rst || stats_clear) cnt_q[g] <= '0;
         else if (done && grant_q == IW'(g)) cnt_q[g] <= cnt_q[g] + 1'b1;
      end
      assign stats_frames[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
   end
`endif
endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// tb_axis_frame_rr_arbiter: self-checking bench for axis_frame_rr_arbiter (2- and 4-input instances)
module tb_axis_frame_rr_arbiter;
   logic clk = 0;
   always #5 clk = ~clk;

   logic         rst2 = 1;
   logic [127:0] d2_data = '0;
   logic [1:0]   d2_last = '0, d2_valid = '0, d2_ready;
   logic [63:0]  o2_data;
   logic         o2_last, o2_valid, o2_ready = 1, g2, busy2;

   logic         rst4 = 1;
   logic [63:0]  d4_data = '0;
   logic [3:0]   d4_last = '0, d4_valid = '0, d4_ready;
   logic [15:0]  o4_data;
   logic         o4_last, o4_valid, o4_ready = 1, busy4;
   logic [1:0]   g4;

`ifdef AXIS_FRAME_ARB_STATS_EN
   logic         clr2 = 0, clr4 = 0;
   logic [63:0]  stats2;
   logic [127:0] stats4;
`endif

   axis_frame_rr_arbiter #(.DATA_WIDTH(64), .INPUTS(2)) u2 (
      .clk(clk), .rst(rst2), .din_data(d2_data), .din_last(d2_last), .din_valid(d2_valid),
      .din_ready(d2_ready), .dout_data(o2_data), .dout_last(o2_last), .dout_valid(o2_valid),
      .dout_ready(o2_ready), .grant_idx(g2), .busy(busy2)
`ifdef AXIS_FRAME_ARB_STATS_EN
      , .stats_clear(clr2), .stats_frames(stats2)
`endif
   );

   axis_frame_rr_arbiter #(.DATA_WIDTH(16), .INPUTS(4)) u4 (
      .clk(clk), .rst(rst4), .din_data(d4_data), .din_last(d4_last), .din_valid(d4_valid),
      .din_ready(d4_ready), .dout_data(o4_data), .dout_last(o4_last), .dout_valid(o4_valid),
      .dout_ready(o4_ready), .grant_idx(g4), .busy(busy4)
`ifdef AXIS_FRAME_ARB_STATS_EN
      , .stats_clear(clr4), .stats_frames(stats4)
`endif
   );

   int nvec = 0, nmis = 0;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      nvec++;
      if (a !== e) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic logic [63:0] bd(input int s, input int tag, input int b);
      return {32'hF00D_0000, 8'(s), 8'(tag), 16'(b)};
   endfunction

   typedef struct {
      logic [1:0]  v, l;
      logic        rdy;
      logic [63:0] d0, d1;
      logic        busy, g, dv, dl;
      logic [1:0]  dr;
      logic [63:0] dd;
   } vec_t;
   vec_t tbl[$];

   typedef struct {logic [63:0] data; logic last;} beat_t;
   beat_t sb[$];

   task automatic reset2();
      rst2 = 1; d2_valid = '0; d2_last = '0; o2_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst2 = 0;
   endtask

   // called #1 after a rising edge; returns #1 after the edge that accepted the last beat
   task automatic send2(input int s, input int n, input int tag);
      bit acc;
      int t;
      for (int b = 0; b < n; b++) begin
         d2_data[s*64 +: 64] = bd(s, tag, b);
         d2_last[s] = (b == n-1);
         d2_valid[s] = 1;
         acc = 0;
         t = 0;
         while (!acc && t < 50) begin
            @(negedge clk) acc = d2_ready[s];
            @(posedge clk);
            #1 t++;
         end
         chk($sformatf("handshake s%0d b%0d", s, b), 64'(acc), 64'd1);
      end
      d2_valid[s] = 0;
      d2_last[s] = 0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl.push_back('{2'b01, 2'b00, 1'b1, 64'hA0, 64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0});
      tbl.push_back('{2'b01, 2'b00, 1'b1, 64'hA0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 64'hA0});
      tbl.push_back('{2'b01, 2'b00, 1'b1, 64'hA1, 64'h0,  1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 64'hA1});
      tbl.push_back('{2'b01, 2'b01, 1'b1, 64'hA2, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 64'hA2});
      tbl.push_back('{2'b00, 2'b00, 1'b1, 64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0});
      tbl.push_back('{2'b10, 2'b00, 1'b1, 64'h0,  64'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0});
      tbl.push_back('{2'b11, 2'b00, 1'b1, 64'hC0, 64'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 64'hB0});
      tbl.push_back('{2'b11, 2'b00, 1'b0, 64'hC0, 64'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 64'hB1});
      tbl.push_back('{2'b11, 2'b00, 1'b1, 64'hC0, 64'hB1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 64'hB1});
      tbl.push_back('{2'b01, 2'b00, 1'b1, 64'hC0, 64'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 64'hB2});
      tbl.push_back('{2'b11, 2'b10, 1'b1, 64'hC0, 64'hB2, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 64'hB2});
      tbl.push_back('{2'b01, 2'b01, 1'b1, 64'hC0, 64'h0,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0});
      tbl.push_back('{2'b01, 2'b01, 1'b1, 64'hC0, 64'h0,  1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 64'hC0});
      tbl.push_back('{2'b00, 2'b00, 1'b1, 64'h0,  64'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0});

      reset2();
      @(negedge clk);
      chk("rst busy", 64'(busy2), 0);
      chk("rst grant", 64'(g2), 0);
      chk("rst dout_valid", 64'(o2_valid), 0);
      chk("rst dout_last", 64'(o2_last), 0);
      chk("rst din_ready", 64'(d2_ready), 0);
      chk("rst dout_data", o2_data, 0);

      foreach (tbl[k]) begin
         @(posedge clk);
         #1;
         d2_valid = tbl[k].v; d2_last = tbl[k].l; o2_ready = tbl[k].rdy;
         d2_data = {tbl[k].d1, tbl[k].d0};
         @(negedge clk);
         chk($sformatf("row%0d busy", k), 64'(busy2), 64'(tbl[k].busy));
         chk($sformatf("row%0d grant", k), 64'(g2), 64'(tbl[k].g));
         chk($sformatf("row%0d dout_valid", k), 64'(o2_valid), 64'(tbl[k].dv));
         chk($sformatf("row%0d dout_last", k), 64'(o2_last), 64'(tbl[k].dl));
         chk($sformatf("row%0d din_ready", k), 64'(d2_ready), 64'(tbl[k].dr));
         chk($sformatf("row%0d dout_data", k), o2_data, tbl[k].dd);
      end

      // continuous 2-beat frames from both inputs: expect order 0,1,0,1 with no interleave
      @(posedge clk);
      reset2();
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < 2; s++)
            for (int b = 0; b < 2; b++) sb.push_back('{bd(s, f, b), b == 1});
      fork
         begin send2(0, 2, 0); send2(0, 2, 1); end
         begin send2(1, 2, 0); send2(1, 2, 1); end
         repeat (40) @(negedge clk) begin
            chk("ready onehot", 64'($countones(d2_ready) <= 1), 1);
            if (o2_valid && o2_ready) begin
               if (sb.size() == 0) chk("sb extra beat", o2_data, 0);
               else begin
                  chk("sb data", o2_data, sb[0].data);
                  chk("sb last", 64'(o2_last), 64'(sb[0].last));
                  void'(sb.pop_front());
               end
            end
         end
      join
      chk("sb beats left", 64'(sb.size()), 0);

      // reset during beat 2 of a 4-beat frame; priority must restart at input 0
      send2(0, 1, 9);
      @(posedge clk);
      #1 d2_valid = 2'b01; d2_last = 2'b00; d2_data[63:0] = bd(0, 5, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 d2_data[63:0] = bd(0, 5, 1);
      @(posedge clk);
      #1 d2_data[63:0] = bd(0, 5, 2); rst2 = 1;
      @(negedge clk);
      chk("mid busy", 64'(busy2), 1);
      chk("mid data", o2_data, bd(0, 5, 2));
      @(posedge clk);
      #1 rst2 = 0; d2_valid = 2'b11; d2_last = 2'b11; d2_data = {bd(1, 7, 0), bd(0, 6, 0)};
      @(negedge clk);
      chk("post rst busy", 64'(busy2), 0);
      chk("post rst din_ready", 64'(d2_ready), 0);
      chk("post rst dout_valid", 64'(o2_valid), 0);
      @(negedge clk);
      chk("post rst grant", 64'(g2), 0);
      chk("post rst data", o2_data, bd(0, 6, 0));
      @(posedge clk);
      #1 d2_valid = 2'b00; d2_last = 2'b00;

      // 4 inputs, requests on 1 and 3 from reset (last_grant=3): 1, 3, then 1 again
      repeat (2) @(posedge clk);
      #1 rst4 = 0;
      @(posedge clk);
      #1 d4_valid = 4'b1010; d4_last = 4'b1010; d4_data = {16'h3333, 16'h0, 16'h1111, 16'h0};
      @(negedge clk);
      chk("q4 idle busy", 64'(busy4), 0);
      @(negedge clk);
      chk("q4 grant a", 64'(g4), 1);
      chk("q4 data a", 64'(o4_data), 64'h1111);
      chk("q4 last a", 64'(o4_last), 1);
      chk("q4 ready a", 64'(d4_ready), 64'b0010);
      @(negedge clk);
      chk("q4 bubble", 64'(busy4), 0);
      @(negedge clk);
      chk("q4 grant b", 64'(g4), 3);
      chk("q4 data b", 64'(o4_data), 64'h3333);
      chk("q4 ready b", 64'(d4_ready), 64'b1000);
      repeat (2) @(negedge clk);
      chk("q4 grant c", 64'(g4), 1);
      @(posedge clk);
      #1 d4_valid = '0; d4_last = '0;

`ifdef AXIS_FRAME_ARB_STATS_EN
      reset2();
      for (int f = 0; f < 5; f++) send2(0, 2, f);
      for (int f = 0; f < 2; f++) send2(1, 1, f);
      @(negedge clk);
      chk("stats 0", stats2[31:0], 5);
      chk("stats 1", stats2[63:32], 2);
      @(posedge clk);
      #1 d2_valid = 2'b01; d2_last = 2'b01;
      @(posedge clk);
      #1 clr2 = 1;
      @(negedge clk);
      chk("clr with last valid", 64'(o2_valid & o2_last), 1);
      @(posedge clk);
      #1 clr2 = 0; d2_valid = 0; d2_last = 0;
      @(negedge clk);
      chk("stats clr 0", stats2[31:0], 0);
      chk("stats clr 1", stats2[63:32], 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
